n8_responder: RTL

//  Device end of the N8 (NES-style) serial pad protocol: emulates the pad's parallel-in/serial-out register.
//  A host (e.g. n8_driver on another board) drives latch/pulse on V_GPIO; this block answers on data.

---
 rtl/n8_pkg.sv | 22 ++
 rtl/n8_responder_sync_edge.sv | 32 +++
 rtl/n8_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/n8_pkg.sv
// Shared N8 pad protocol definitions: FSM state type and button bit positions.
package n8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } n8_state_t;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam int unsigned N8_NUM_BITS = 8;

endpackage

// File: rtl/n8_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a single
// history flop that yields one-cycle rise/fall strobes on the clean level.
module n8_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw pin through the synchronizer chain and remember the last clean level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/n8_responder.sv
// Device side of the N8 serial pad protocol: captures buttons while the host
// holds latch, then presents them LSB-first on data_out, one bit per pulse.
module n8_responder
  import n8_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned NUM_BITS       = N8_NUM_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic        IDLE_LEVEL     = 1'b1
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [NUM_BITS-1:0] buttons,
  input  logic                latch_in,
  input  logic                pulse_in,
  output logic                data_out,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_abort,
  output logic                timeout_err,
  output logic [15:0]         frame_count
);

  localparam int unsigned CW = $clog2(NUM_BITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic latch_level, latch_rise, latch_fall;
  logic pulse_rise, pulse_level_unused, pulse_fall_unused;

  n8_state_t           state_q;
  logic [NUM_BITS-1:0] shreg_q;
  logic [CW-1:0]       bit_cnt_q;
  logic [TW-1:0]       timer_q;
  logic                data_out_q;
  logic                busy_q;
  logic                frame_done_q;
  logic                frame_abort_q;
  logic                timeout_err_q;
  logic [15:0]         frame_count_q;

  n8_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk_i   (CLOCK_50),
    .rst_ni  (reset_n),
    .async_i (latch_in),
    .level_o (latch_level),
    .rise_o  (latch_rise),
    .fall_o  (latch_fall)
  );

  n8_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk_i   (CLOCK_50),
    .rst_ni  (reset_n),
    .async_i (pulse_in),
    .level_o (pulse_level_unused),
    .rise_o  (pulse_rise),
    .fall_o  (pulse_fall_unused)
  );

  // Protocol FSM with shift register, bit counter, inactivity timer and registered outputs.
  // Latch-high is tested before timeout and pulse so a re-latch always wins.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      shreg_q       <= {NUM_BITS{IDLE_LEVEL}};
      bit_cnt_q     <= '0;
      timer_q       <= '0;
      data_out_q    <= IDLE_LEVEL;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          data_out_q <= IDLE_LEVEL;
          if (latch_level) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            shreg_q    <= ~buttons;
            data_out_q <= ~buttons[0];
            bit_cnt_q  <= '0;
            timer_q    <= '0;
          end
        end
        LOAD: begin
          shreg_q    <= ~buttons;
          data_out_q <= ~buttons[0];
          bit_cnt_q  <= '0;
          timer_q    <= '0;
          if (latch_fall) begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (latch_level) begin
            frame_abort_q <= 1'b1;
            state_q       <= LOAD;
            shreg_q       <= ~buttons;
            data_out_q    <= ~buttons[0];
            bit_cnt_q     <= '0;
            timer_q       <= '0;
          end else if (timer_q == TIMER_MAX) begin
            timeout_err_q <= 1'b1;
            data_out_q    <= IDLE_LEVEL;
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            timer_q       <= '0;
          end else if (pulse_rise) begin
            timer_q   <= '0;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            shreg_q   <= {IDLE_LEVEL, shreg_q[NUM_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              data_out_q    <= IDLE_LEVEL;
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
              state_q       <= DONE;
              busy_q        <= 1'b0;
            end else begin
              data_out_q <= shreg_q[1];
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE: begin
          data_out_q <= IDLE_LEVEL;
          if (latch_rise) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            shreg_q    <= ~buttons;
            data_out_q <= ~buttons[0];
            bit_cnt_q  <= '0;
            timer_q    <= '0;
          end
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          data_out_q <= IDLE_LEVEL;
        end
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign timeout_err = timeout_err_q;
  assign frame_count = frame_count_q;

endmodule
